// File: rtl/ddr_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr_arb_pkg
// Shared types and constants for the ddr_arbiter front end:
//   - arb_state_e : arbiter FSM states (IDLE, BUSY)
//   - req_id_e    : requester identity (REQ_FETCH, REQ_LSU)
//   - DDR_LINE_W  : width of a fetch burst line (512)
//   - DDR_WORD_W  : width of a single LSU word (64)
//   - rr_pick     : two-way round-robin winner selection
// ---------------------------------------------------------------------------
package ddr_arb_pkg;

  localparam int DDR_LINE_W = 512;
  localparam int DDR_WORD_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LSU   = 1'b1
  } req_id_e;

  // On a tie the requester that was not served last wins; otherwise the
  // single active requester wins. With no request the result is don't-care.
  function automatic req_id_e rr_pick(input logic    fetch_req,
                                      input logic    lsu_req,
                                      input req_id_e last_grant);
    req_id_e win;
    if (fetch_req && lsu_req) begin
      if (last_grant == REQ_FETCH) begin
        win = REQ_LSU;
      end else begin
        win = REQ_FETCH;
      end
    end else if (lsu_req) begin
      win = REQ_LSU;
    end else begin
      win = REQ_FETCH;
    end
    return win;
  endfunction

endpackage

// File: rtl/ddr_arbiter_if.sv
// ---------------------------------------------------------------------------
// ddr_arbiter_if
// Bundles the fetch, LSU and simddr command/response signals of the arbiter.
//   slave  modport : the arbiter's view (accepts requests, drives DDR command,
//                    returns responses)
//   master modport : the environment's view (requesters and the DDR device)
// Parameter ADDR_WIDTH : word address width (default 19).
// ---------------------------------------------------------------------------
interface ddr_arbiter_if #(
  parameter int ADDR_WIDTH = 19
);
  import ddr_arb_pkg::*;

  // fetch requester
  logic                  fetch_req_valid;
  logic                  fetch_req_ready;
  logic [ADDR_WIDTH-1:0] fetch_req_addr;
  logic                  fetch_flush;
  logic                  fetch_resp_valid;
  logic [DDR_LINE_W-1:0] fetch_resp_data;

  // LSU requester
  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic                  lsu_req_wen;
  logic [ADDR_WIDTH-1:0] lsu_req_addr;
  logic [DDR_WORD_W-1:0] lsu_req_wdata;
  logic [DDR_WORD_W-1:0] lsu_req_wmask;
  logic                  lsu_resp_valid;
  logic [DDR_WORD_W-1:0] lsu_resp_rdata;

  // simddr port
  logic                  ddr_chip_enable;
  logic                  ddr_write_enable;
  logic                  ddr_burst_mode;
  logic [ADDR_WIDTH-1:0] ddr_address;
  logic [DDR_WORD_W-1:0] ddr_write_mask;
  logic [DDR_WORD_W-1:0] ddr_write_data;
  logic [DDR_LINE_W-1:0] ddr_burst_write_data;
  logic [DDR_LINE_W-1:0] ddr_burst_read_data;
  logic [DDR_WORD_W-1:0] ddr_read_data;
  logic                  ddr_operation_done;

  modport slave (
    input  fetch_req_valid, fetch_req_addr, fetch_flush,
    output fetch_req_ready, fetch_resp_valid, fetch_resp_data,
    input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    output ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_address,
    output ddr_write_mask, ddr_write_data, ddr_burst_write_data,
    input  ddr_burst_read_data, ddr_read_data, ddr_operation_done
  );

  modport master (
    output fetch_req_valid, fetch_req_addr, fetch_flush,
    input  fetch_req_ready, fetch_resp_valid, fetch_resp_data,
    output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    input  ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_address,
    input  ddr_write_mask, ddr_write_data, ddr_burst_write_data,
    output ddr_burst_read_data, ddr_read_data, ddr_operation_done
  );

endinterface

// File: rtl/ddr_arb_rr.sv
// ---------------------------------------------------------------------------
// ddr_arb_rr
// Two-input round-robin grant generator.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   req_fetch    : fetch is requesting (already qualified by flush)
//   req_lsu      : LSU is requesting
//   accept       : the granted request was accepted this cycle
//   grant_fetch  : fetch wins this cycle
//   grant_lsu    : LSU wins this cycle
// The remembered last grant resets to REQ_FETCH so LSU wins the first tie.
// ---------------------------------------------------------------------------
module ddr_arb_rr
  import ddr_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_fetch,
  input  logic req_lsu,
  input  logic accept,
  output logic grant_fetch,
  output logic grant_lsu
);

  req_id_e last_grant_r;
  req_id_e winner_s;

  // Combinational winner selection and one-hot grant.
  always_comb begin
    winner_s    = rr_pick(req_fetch, req_lsu, last_grant_r);
    grant_fetch = 1'b0;
    grant_lsu   = 1'b0;
    if (req_fetch || req_lsu) begin
      if (winner_s == REQ_FETCH) begin
        grant_fetch = 1'b1;
      end else begin
        grant_lsu = 1'b1;
      end
    end else begin
      grant_fetch = 1'b0;
      grant_lsu   = 1'b0;
    end
  end

  // Remember who was served; only a real accept moves the pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_r <= REQ_FETCH;
    end else if (accept) begin
      last_grant_r <= winner_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/ddr_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_arbiter
// Two-requester front end for simddr: arbitrates fetch burst reads (512-bit)
// and LSU word reads/writes (64-bit) onto one DDR port, holds the command
// stable for the whole operation and returns one-cycle response pulses.
// Ports:
//   clk          : sole clock, rising edge
//   rst_n        : synchronous active-low reset
//   bus          : ddr_arbiter_if.slave (fetch, LSU and simddr signals)
//   timeout_err  : sticky flag, set when BUSY lasts TIMEOUT_CYCLES cycles
// Parameters:
//   ADDR_WIDTH     : word address width (must match the interface)
//   TIMEOUT_CYCLES : BUSY cycles without done before timeout_err is set
// ---------------------------------------------------------------------------
module ddr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 19,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic          clk,
  input  logic          rst_n,
  ddr_arbiter_if.slave  bus,
  output logic          timeout_err
);

  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT_CYCLES);

  arb_state_e            state_r;
  req_id_e               id_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  wen_r;
  logic [DDR_WORD_W-1:0] wdata_r;
  logic [DDR_WORD_W-1:0] wmask_r;
  logic                  drop_r;
  logic [31:0]           wd_cnt_r;
  logic                  timeout_err_r;
  logic                  fetch_resp_valid_r;
  logic [DDR_LINE_W-1:0] fetch_resp_data_r;
  logic                  lsu_resp_valid_r;
  logic [DDR_WORD_W-1:0] lsu_resp_data_r;

  logic fetch_req_s;
  logic grant_fetch_s;
  logic grant_lsu_s;
  logic idle_s;
  logic busy_s;
  logic fetch_hs_s;
  logic lsu_hs_s;
  logic accept_s;

  // A fetch raised together with a flush is neither granted nor accepted.
  assign fetch_req_s = bus.fetch_req_valid && !bus.fetch_flush;
  assign idle_s      = (state_r == IDLE);
  assign busy_s      = (state_r == BUSY);

  ddr_arb_rr u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_fetch   (fetch_req_s),
    .req_lsu     (bus.lsu_req_valid),
    .accept      (accept_s),
    .grant_fetch (grant_fetch_s),
    .grant_lsu   (grant_lsu_s)
  );

  // Ready only for the winner, only in IDLE and never while reset is held.
  assign bus.fetch_req_ready = rst_n && idle_s && grant_fetch_s;
  assign bus.lsu_req_ready   = rst_n && idle_s && grant_lsu_s;

  assign fetch_hs_s = bus.fetch_req_valid && bus.fetch_req_ready;
  assign lsu_hs_s   = bus.lsu_req_valid && bus.lsu_req_ready;
  assign accept_s   = fetch_hs_s || lsu_hs_s;

  // chip_enable drops in the done cycle so simddr does not start again.
  assign bus.ddr_chip_enable      = busy_s && !bus.ddr_operation_done;
  assign bus.ddr_burst_mode       = busy_s && (id_r == REQ_FETCH);
  assign bus.ddr_write_enable     = busy_s && (id_r == REQ_LSU) && wen_r;
  assign bus.ddr_address          = addr_r;
  assign bus.ddr_write_mask       = wmask_r;
  assign bus.ddr_write_data       = wdata_r;
  assign bus.ddr_burst_write_data = {DDR_LINE_W{1'b0}};

  assign bus.fetch_resp_valid = fetch_resp_valid_r;
  assign bus.fetch_resp_data  = fetch_resp_data_r;
  assign bus.lsu_resp_valid   = lsu_resp_valid_r;
  assign bus.lsu_resp_rdata   = lsu_resp_data_r;
  assign timeout_err          = timeout_err_r;

  // Arbiter FSM: command latches, response registers, drop flag, watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r            <= IDLE;
      id_r               <= REQ_FETCH;
      addr_r             <= {ADDR_WIDTH{1'b0}};
      wen_r              <= 1'b0;
      wdata_r            <= {DDR_WORD_W{1'b0}};
      wmask_r            <= {DDR_WORD_W{1'b0}};
      drop_r             <= 1'b0;
      wd_cnt_r           <= 32'd0;
      timeout_err_r      <= 1'b0;
      fetch_resp_valid_r <= 1'b0;
      fetch_resp_data_r  <= {DDR_LINE_W{1'b0}};
      lsu_resp_valid_r   <= 1'b0;
      lsu_resp_data_r    <= {DDR_WORD_W{1'b0}};
    end else begin
      // Response valids are single-cycle pulses.
      fetch_resp_valid_r <= 1'b0;
      lsu_resp_valid_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          drop_r   <= 1'b0;
          wd_cnt_r <= 32'd0;
          if (fetch_hs_s) begin
            state_r <= BUSY;
            id_r    <= REQ_FETCH;
            addr_r  <= bus.fetch_req_addr;
            wen_r   <= 1'b0;
            wdata_r <= {DDR_WORD_W{1'b0}};
            wmask_r <= {DDR_WORD_W{1'b0}};
          end else if (lsu_hs_s) begin
            state_r <= BUSY;
            id_r    <= REQ_LSU;
            addr_r  <= bus.lsu_req_addr;
            wen_r   <= bus.lsu_req_wen;
            wdata_r <= bus.lsu_req_wdata;
            wmask_r <= bus.lsu_req_wmask;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (bus.ddr_operation_done) begin
            state_r  <= IDLE;
            drop_r   <= 1'b0;
            wd_cnt_r <= 32'd0;
            if (id_r == REQ_FETCH) begin
              // A flush in the done cycle itself also cancels the response.
              if (!(drop_r || bus.fetch_flush)) begin
                fetch_resp_valid_r <= 1'b1;
                fetch_resp_data_r  <= bus.ddr_burst_read_data;
              end else begin
                fetch_resp_valid_r <= 1'b0;
              end
            end else begin
              lsu_resp_valid_r <= 1'b1;
              lsu_resp_data_r  <= wen_r ? {DDR_WORD_W{1'b0}} : bus.ddr_read_data;
            end
          end else begin
            state_r <= BUSY;
            if ((id_r == REQ_FETCH) && bus.fetch_flush) begin
              drop_r <= 1'b1;
            end else begin
              drop_r <= drop_r;
            end
            // Saturating watchdog; the error is sticky until reset.
            if (wd_cnt_r != TIMEOUT_C) begin
              wd_cnt_r <= wd_cnt_r + 32'd1;
            end else begin
              wd_cnt_r <= wd_cnt_r;
            end
            if ((wd_cnt_r + 32'd1) == TIMEOUT_C) begin
              timeout_err_r <= 1'b1;
            end else begin
              timeout_err_r <= timeout_err_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_arbiter
// Scoreboard bench for ddr_arbiter. A small simddr-like model (done at A+66
// for single accesses, A+82 for bursts) serves the main instance; a second
// instance with TIMEOUT_CYCLES = 20 and done tied low exercises the watchdog
// and a mid-BUSY reset.
// ---------------------------------------------------------------------------
module tb_ddr_arbiter;
  import ddr_arb_pkg::*;

  localparam int AW        = 19;
  localparam int MEM_WORDS = 1024;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic rst_wd_n = 1'b0;
  logic timeout_err;
  logic wd_timeout_err;

  int cyc           = 0;
  int passed        = 0;
  int total         = 0;
  int last_done_cyc = -10;

  logic [DDR_LINE_W-1:0] exp_fetch_q [$];
  logic [DDR_WORD_W-1:0] exp_lsu_q [$];

  ddr_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  ddr_arbiter_if #(.ADDR_WIDTH(AW)) wbus ();

  ddr_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .timeout_err(timeout_err)
  );

  ddr_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(20)) dut_wd (
    .clk(clk), .rst_n(rst_wd_n), .bus(wbus), .timeout_err(wd_timeout_err)
  );

  always #5 clk = ~clk;

  // Cycle counter used for response and re-grant timing.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input int i);
    logic [63:0] w;
    if (i == 32'h10)      w = 64'hDEAD_BEEF_0000_0001;
    else if (i == 32'h20) w = 64'hAAAA_BBBB_CCCC_DDDD;
    else                  w = {32'hC0DE_0000 | 32'(i), 32'h1234_5000 + 32'(i)};
    return w;
  endfunction

  function automatic logic [511:0] init_line(input int base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[64*i +: 64] = init_word(base + i);
    return l;
  endfunction

  // ---------------- simddr-like model ----------------
  logic [63:0] mem [0:MEM_WORDS-1];
  logic        m_busy;
  int          m_cnt;
  int          m_lat;

  function automatic logic [511:0] line_from_mem(input logic [9:0] base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[64*i +: 64] = mem[base + 10'(i)];
    return l;
  endfunction

  // DDR model: starts on chip_enable, raises done once after a fixed latency.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
      m_busy                  <= 1'b0;
      m_cnt                   <= 0;
      m_lat                   <= 0;
      bus.ddr_operation_done  <= 1'b0;
      bus.ddr_read_data       <= 64'd0;
      bus.ddr_burst_read_data <= 512'd0;
    end else if (!m_busy) begin
      if (bus.ddr_chip_enable) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        m_lat  <= bus.ddr_burst_mode ? 81 : 65;
      end
    end else if (bus.ddr_operation_done) begin
      m_busy                 <= 1'b0;
      bus.ddr_operation_done <= 1'b0;
    end else if (m_cnt == m_lat - 1) begin
      bus.ddr_operation_done <= 1'b1;
      if (bus.ddr_burst_mode)
        bus.ddr_burst_read_data <= line_from_mem(bus.ddr_address[9:0]);
      else if (bus.ddr_write_enable)
        mem[bus.ddr_address[9:0]] <= (mem[bus.ddr_address[9:0]] & ~bus.ddr_write_mask)
                                   | (bus.ddr_write_data & bus.ddr_write_mask);
      else
        bus.ddr_read_data <= mem[bus.ddr_address[9:0]];
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [DDR_LINE_W-1:0] ef;
    logic [DDR_WORD_W-1:0] el;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ddr_operation_done) begin
          last_done_cyc = cyc;
          chk("ce_low_in_done", 64'(bus.ddr_chip_enable), 64'd0);
        end
        if (bus.fetch_resp_valid) begin
          if (exp_fetch_q.size() == 0) begin
            total++;
            $display("FAIL fetch_resp_unexpected: got valid with data %h expected no response", bus.fetch_resp_data);
          end else begin
            ef = exp_fetch_q.pop_front();
            total++;
            if (bus.fetch_resp_data === ef) passed++;
            else $display("FAIL fetch_resp_data: got %h expected %h", bus.fetch_resp_data, ef);
          end
          chk("fetch_resp_at_d1", 64'(cyc), 64'(last_done_cyc + 1));
        end
        if (bus.lsu_resp_valid) begin
          if (exp_lsu_q.size() == 0) begin
            total++;
            $display("FAIL lsu_resp_unexpected: got valid with data %h expected no response", bus.lsu_resp_rdata);
          end else begin
            el = exp_lsu_q.pop_front();
            chk("lsu_resp_data", bus.lsu_resp_rdata, el);
          end
          chk("lsu_resp_at_d1", 64'(cyc), 64'(last_done_cyc + 1));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input bit is_fetch, input string name, output int c);
    c = -1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if ((is_fetch && bus.fetch_req_ready) || (!is_fetch && bus.lsu_req_ready)) begin
        c = cyc;
        break;
      end
      @(negedge clk);
    end
    if (c < 0) begin
      total++;
      $display("FAIL %s: ready not seen within 400 cycles", name);
    end
  endtask

  task automatic check_issue(input string name, input logic burst, input logic we,
                             input logic [AW-1:0] a);
    @(negedge clk);
    chk({name, "_ce"}, 64'(bus.ddr_chip_enable), 64'd1);
    chk({name, "_burst"}, 64'(bus.ddr_burst_mode), 64'(burst));
    chk({name, "_we"}, 64'(bus.ddr_write_enable), 64'(we));
    chk({name, "_addr"}, 64'(bus.ddr_address), 64'(a));
  endtask

  task automatic issue_lsu(input string name, input logic [AW-1:0] a, input logic wen,
                           input logic [63:0] wd, input logic [63:0] wm, input logic [63:0] exp);
    int c;
    bus.lsu_req_addr  = a;
    bus.lsu_req_wen   = wen;
    bus.lsu_req_wdata = wd;
    bus.lsu_req_wmask = wm;
    bus.lsu_req_valid = 1'b1;
    exp_lsu_q.push_back(exp);
    wait_ready(1'b0, name, c);
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    check_issue(name, 1'b0, wen, a);
  endtask

  task automatic issue_fetch(input string name, input logic [AW-1:0] a);
    int c;
    bus.fetch_req_addr  = a;
    bus.fetch_req_valid = 1'b1;
    exp_fetch_q.push_back(init_line(int'(a)));
    wait_ready(1'b1, name, c);
    @(posedge clk); #1;
    bus.fetch_req_valid = 1'b0;
    check_issue(name, 1'b1, 1'b0, a);
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_fetch_q.size() == 0 && exp_lsu_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      $display("FAIL %s: responses still pending after 400 cycles", name);
    end
    @(negedge clk);
  endtask

  // Absolute time bound on the whole run.
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global time bound exceeded");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int  c;
    bit  seen;
    bus.fetch_req_valid = 1'b0;
    bus.fetch_req_addr  = '0;
    bus.fetch_flush     = 1'b0;
    bus.lsu_req_valid   = 1'b0;
    bus.lsu_req_wen     = 1'b0;
    bus.lsu_req_addr    = '0;
    bus.lsu_req_wdata   = 64'd0;
    bus.lsu_req_wmask   = 64'd0;
    wbus.fetch_req_valid     = 1'b0;
    wbus.fetch_req_addr      = '0;
    wbus.fetch_flush         = 1'b0;
    wbus.lsu_req_valid       = 1'b0;
    wbus.lsu_req_wen         = 1'b0;
    wbus.lsu_req_addr        = '0;
    wbus.lsu_req_wdata       = 64'd0;
    wbus.lsu_req_wmask       = 64'd0;
    wbus.ddr_burst_read_data = 512'd0;
    wbus.ddr_read_data       = 64'd0;
    wbus.ddr_operation_done  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_ready", 64'(bus.fetch_req_ready), 64'd0);
    chk("rst_lsu_ready", 64'(bus.lsu_req_ready), 64'd0);
    chk("rst_ce", 64'(bus.ddr_chip_enable), 64'd0);
    chk("rst_burst", 64'(bus.ddr_burst_mode), 64'd0);
    chk("rst_we", 64'(bus.ddr_write_enable), 64'd0);
    chk("rst_addr", 64'(bus.ddr_address), 64'd0);
    chk("rst_resp_valids", 64'({bus.fetch_resp_valid, bus.lsu_resp_valid}), 64'd0);
    chk("rst_lsu_rdata", bus.lsu_resp_rdata, 64'd0);
    chk("rst_fetch_data_zero", 64'(bus.fetch_resp_data != 512'd0), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    rst_n    = 1'b1;
    rst_wd_n = 1'b1;
    @(negedge clk);

    // LSU read alone
    issue_lsu("lsu_rd10", 19'h00010, 1'b0, 64'd0, 64'd0, 64'hDEAD_BEEF_0000_0001);
    wait_drain("lsu_rd10_drain");

    // Fetch burst
    issue_fetch("fetch100", 19'h00100);
    wait_drain("fetch100_drain");

    // Tie 1: LSU wins, fetch held
    bus.fetch_req_addr  = 19'h00108;
    bus.fetch_req_valid = 1'b1;
    bus.lsu_req_addr    = 19'h00010;
    bus.lsu_req_wen     = 1'b0;
    bus.lsu_req_valid   = 1'b1;
    #1;
    chk("tie1_lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    chk("tie1_fetch_held", 64'(bus.fetch_req_ready), 64'd0);
    exp_lsu_q.push_back(64'hDEAD_BEEF_0000_0001);
    exp_fetch_q.push_back(init_line(32'h108));
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    // Tie 2: fetch granted at D+1
    wait_ready(1'b1, "tie2_fetch", c);
    chk("tie2_fetch_at_d1", 64'(c), 64'(last_done_cyc + 1));
    @(posedge clk); #1;
    // Tie 3: both valid again, LSU wins
    bus.fetch_req_addr = 19'h00100;
    exp_fetch_q.push_back(init_line(32'h100));
    bus.lsu_req_addr  = 19'h00020;
    bus.lsu_req_valid = 1'b1;
    exp_lsu_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
    wait_ready(1'b0, "tie3_lsu", c);
    chk("tie3_lsu_at_d1", 64'(c), 64'(last_done_cyc + 1));
    chk("tie3_fetch_held", 64'(bus.fetch_req_ready), 64'd0);
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    wait_ready(1'b1, "tie3_fetch_next", c);
    @(posedge clk); #1;
    bus.fetch_req_valid = 1'b0;
    wait_drain("tie_drain");

    // LSU write with low-half mask, then read back
    issue_lsu("lsu_wr20", 19'h00020, 1'b1, 64'h1122_3344_5566_7788, 64'h0000_0000_FFFF_FFFF, 64'd0);
    wait_drain("lsu_wr20_drain");
    issue_lsu("lsu_rd20", 19'h00020, 1'b0, 64'd0, 64'd0, 64'hAAAA_BBBB_5566_7788);
    wait_drain("lsu_rd20_drain");

    // Fetch flush at A+30 with LSU queued behind it
    bus.fetch_req_addr  = 19'h00100;
    bus.fetch_req_valid = 1'b1;
    wait_ready(1'b1, "flush_fetch", c);
    @(posedge clk); #1;
    bus.fetch_req_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    bus.fetch_flush   = 1'b1;
    bus.lsu_req_addr  = 19'h00010;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_valid = 1'b1;
    exp_lsu_q.push_back(64'hDEAD_BEEF_0000_0001);
    @(posedge clk); #1;
    bus.fetch_flush = 1'b0;
    wait_ready(1'b0, "flush_lsu", c);
    chk("flush_lsu_at_d1", 64'(c), 64'(last_done_cyc + 1));
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    wait_drain("flush_drain");

    // Watchdog on the second instance (done never arrives)
    wbus.fetch_req_addr  = 19'h00040;
    wbus.fetch_req_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (wbus.fetch_req_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wd_fetch_ready", 64'(seen), 64'd1);
    @(posedge clk); #1;
    wbus.fetch_req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) chk("wd_not_yet_at_20", 64'(wd_timeout_err), 64'd0);
      if (k == 21) chk("wd_set_after_20", 64'(wd_timeout_err), 64'd1);
    end
    chk("wd_sticky", 64'(wd_timeout_err), 64'd1);
    chk("wd_still_busy", 64'(wbus.ddr_chip_enable), 64'd1);

    // One-edge reset in the middle of BUSY
    rst_wd_n = 1'b0;
    @(posedge clk); #1;
    rst_wd_n = 1'b1;
    @(negedge clk);
    chk("wdrst_ce", 64'(wbus.ddr_chip_enable), 64'd0);
    chk("wdrst_timeout", 64'(wd_timeout_err), 64'd0);
    chk("wdrst_burst_addr", 64'({wbus.ddr_burst_mode, wbus.ddr_address}), 64'd0);
    chk("wdrst_resp_valids", 64'({wbus.fetch_resp_valid, wbus.lsu_resp_valid}), 64'd0);
    wbus.lsu_req_valid = 1'b1;
    #1;
    chk("wdrst_idle_ready", 64'(wbus.lsu_req_ready), 64'd1);
    wbus.lsu_req_valid = 1'b0;
    @(negedge clk);

    chk("fetch_queue_empty", 64'(exp_fetch_q.size()), 64'd0);
    chk("lsu_queue_empty", 64'(exp_lsu_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
